// File: rtl/bnn_layer_seq.sv
// Sequencer for one fully connected binary layer: streams activation/weight words,
// accumulates XNOR-popcount per neuron, thresholds it and writes one output bit.
module bnn_layer_seq #(
  parameter int WORD_W    = 16,
  parameter int N_WORDS   = 49,
  parameter int N_NEURONS = 32,
  parameter int ACC_W     = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   rd_en,
  output logic [$clog2(N_WORDS)-1:0]             act_addr,
  output logic [$clog2(N_NEURONS*N_WORDS)-1:0]   wgt_addr,
  input  logic [WORD_W-1:0]                      act_data,
  input  logic [WORD_W-1:0]                      wgt_data,
  output logic [$clog2(N_NEURONS)-1:0]           thr_addr,
  input  logic [ACC_W-1:0]                       thresh,
  output logic                                   out_we,
  output logic [$clog2(N_NEURONS)-1:0]           out_addr,
  output logic                                   out_bit
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | issuing one activation/weight read per cycle
  // DRAIN | accumulating the last returned word
  // WRITE | writing the thresholded output bit
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int AW = $clog2(N_WORDS);
  localparam int WW = $clog2(N_NEURONS*N_WORDS);
  localparam int NW = $clog2(N_NEURONS);

  state_t            state_q, state_d;
  logic [AW-1:0]     word_idx_q;
  logic [NW-1:0]     neuron_q;
  logic [WW-1:0]     wgt_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [NW-1:0]     out_addr_q;
  logic              out_bit_q;

  logic              word_last;
  logic              neuron_last;
  logic [ACC_W-1:0]  acc_sum;

  function automatic logic [ACC_W-1:0] popcnt(input logic [WORD_W-1:0] v);
    logic [ACC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c = c + ACC_W'(v[i]);
    return c;
  endfunction

  assign word_last   = (word_idx_q == AW'(N_WORDS - 1));
  assign neuron_last = (neuron_q == NW'(N_NEURONS - 1));
  assign acc_sum     = acc_q + popcnt(~(act_data ^ wgt_data));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (word_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = neuron_last ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx_q <= '0;
      neuron_q   <= '0;
      wgt_cnt_q  <= '0;
      acc_q      <= '0;
      out_addr_q <= '0;
      out_bit_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            word_idx_q <= '0;
            neuron_q   <= '0;
            wgt_cnt_q  <= '0;
          end
        end
        S_FETCH: begin
          // Counters park on the last address so the address outputs hold it after FETCH.
          if (!word_last) begin
            word_idx_q <= word_idx_q + AW'(1);
            wgt_cnt_q  <= wgt_cnt_q + WW'(1);
          end
          acc_q <= (word_idx_q == '0) ? '0 : acc_sum;
        end
        S_DRAIN: begin
          // Result is registered here so out_bit is valid and glitch-free throughout WRITE;
          // thr_addr has been stable since the neuron's first FETCH, so thresh is settled.
          acc_q      <= acc_sum;
          out_addr_q <= neuron_q;
          out_bit_q  <= (acc_sum >= thresh);
        end
        S_WRITE: begin
          if (!neuron_last) begin
            neuron_q   <= neuron_q + NW'(1);
            word_idx_q <= '0;
            wgt_cnt_q  <= wgt_cnt_q + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign rd_en    = (state_q == S_FETCH);
  assign out_we   = (state_q == S_WRITE);
  assign act_addr = word_idx_q;
  assign wgt_addr = wgt_cnt_q;
  assign thr_addr = neuron_q;
  assign out_addr = out_addr_q;
  assign out_bit  = out_bit_q;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq: threshold boundaries, cycle timing, addressing,
// start handling and mid-run reset, with a one-cycle-latency memory model.
module tb_bnn_layer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, rd_en, out_we, out_bit;
  logic [5:0]  act_addr;
  logic [10:0] wgt_addr;
  logic [4:0]  thr_addr, out_addr;
  logic [15:0] act_data = '0, wgt_data = '0;
  logic [9:0]  thresh;
  logic [15:0] act_pat, wgt_pat;

  int n_vec = 0;
  int n_err = 0;

  bnn_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .act_addr(act_addr), .wgt_addr(wgt_addr), .act_data(act_data), .wgt_data(wgt_data),
    .thr_addr(thr_addr), .thresh(thresh), .out_we(out_we), .out_addr(out_addr),
    .out_bit(out_bit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      act_data <= act_pat;
      wgt_data <= wgt_pat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_layer(input string tag, input logic [15:0] a, input logic [15:0] w,
                           input logic [9:0] th, input logic eb, input bit pulse_mid);
    int rd_cnt = 0, we_cnt = 0, ones = 0, first_rd = -1, first_we = -1;
    int done_k = -1, done_cnt = 0, wa_err = 0, aa_err = 0, oa_err = 0, busy_err = 0;
    int idle_busy = 0;
    logic busy_end = 1'bx;
    act_pat = a; wgt_pat = w; thresh = th;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 1634; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (pulse_mid && k == 160) start = 1'b1;
      if (pulse_mid && k == 161) start = 1'b0;
      if (rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = k;
        if (wgt_addr !== 11'(rd_cnt)) wa_err++;
        if (act_addr !== 6'(rd_cnt % 49)) aa_err++;
        rd_cnt++;
      end
      if (out_we === 1'b1) begin
        if (first_we < 0) first_we = k;
        if (out_addr !== 5'(we_cnt) || thr_addr !== 5'(we_cnt)) oa_err++;
        if (out_bit === 1'b1) ones++;
        we_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k <= 1633 && busy !== 1'b1) busy_err++;
      if (k == 1634) busy_end = busy;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) idle_busy++;
    end
    chk({tag, ".first_rd"}, first_rd, 1);
    chk({tag, ".first_we"}, first_we, 51);
    chk({tag, ".done_cyc"}, done_k, 1633);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".busy_run"}, busy_err, 0);
    chk({tag, ".busy_end"}, 32'(busy_end), 0);
    chk({tag, ".rd_cnt"}, rd_cnt, 1568);
    chk({tag, ".wgt_seq"}, wa_err, 0);
    chk({tag, ".act_seq"}, aa_err, 0);
    chk({tag, ".we_cnt"}, we_cnt, 32);
    chk({tag, ".oaddr_seq"}, oa_err, 0);
    chk({tag, ".ones"}, ones, eb ? 32 : 0);
    chk({tag, ".idle_after"}, idle_busy, 0);
  endtask

  initial begin
    int done1, done2, low_cnt, low_k, done_cnt;
    logic [31:0] restart_probe, busy_tail;

    // Reset with random inputs
    rst = 1'b1; start = 1'b0; thresh = '0; act_pat = '0; wgt_pat = '0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_outs", {busy, done, rd_en, out_we, act_addr, wgt_addr, thr_addr, out_addr, out_bit}, 0);
      start = 1'($urandom_range(0, 1));
      thresh = 10'($urandom);
      act_pat = 16'($urandom);
      wgt_pat = 16'($urandom);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_hold", {busy, rd_en, out_we, done}, 0);
    end

    // Threshold boundaries and data patterns
    run_layer("all784", 16'hFFFF, 16'hFFFF, 10'd784, 1'b1, 1'b0);
    run_layer("all785", 16'hFFFF, 16'hFFFF, 10'd785, 1'b0, 1'b0);
    run_layer("aa392",  16'hAAAA, 16'hFFFF, 10'd392, 1'b1, 1'b0);
    run_layer("aa393",  16'hAAAA, 16'hFFFF, 10'd393, 1'b0, 1'b0);
    run_layer("zero0",  16'h0000, 16'hFFFF, 10'd0,   1'b1, 1'b0);
    run_layer("zero1",  16'h0000, 16'hFFFF, 10'd1,   1'b0, 1'b0);
    // xnor(0x1234,0x00FF)=0xED34 -> 9 ones/word -> 441
    run_layer("mix441", 16'h1234, 16'h00FF, 10'd441, 1'b1, 1'b0);
    run_layer("mix442", 16'h1234, 16'h00FF, 10'd442, 1'b0, 1'b0);

    // start pulse in FETCH of neuron 3 is ignored
    run_layer("pulse", 16'hFFFF, 16'hFFFF, 10'd784, 1'b1, 1'b1);

    // start held high: back-to-back runs with one IDLE cycle between
    done1 = -1; done2 = -1; low_cnt = 0; low_k = -1; restart_probe = 'x; busy_tail = 'x;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 3268; k++) begin
      @(negedge clk);
      if (k == 1635) begin
        restart_probe = {20'd0, rd_en, wgt_addr};
        start = 1'b0;
      end
      if (done === 1'b1) begin
        if (done1 < 0) done1 = k;
        else if (done2 < 0) done2 = k;
      end
      if (k <= 3267 && busy !== 1'b1) begin
        low_cnt++;
        if (low_k < 0) low_k = k;
      end
      if (k == 3268) busy_tail = 32'(busy);
    end
    chk("hold.done1", done1, 1633);
    chk("hold.done2", done2, 3267);
    chk("hold.idle_cnt", low_cnt, 1);
    chk("hold.idle_cyc", low_k, 1634);
    chk("hold.restart", restart_probe, {20'd0, 1'b1, 11'd0});
    chk("hold.busy_tail", busy_tail, 0);

    // Reset during WRITE of neuron 5
    act_pat = 16'hFFFF; wgt_pat = 16'hFFFF; thresh = 10'd784;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 306; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("mid.write5", {out_we, out_addr}, {1'b1, 5'd5});
    rst = 1'b1;
    @(negedge clk);
    chk("mid.after_rst", {busy, out_we, rd_en, done, wgt_addr, act_addr, thr_addr}, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("mid.no_done", done_cnt, 0);
    run_layer("restart", 16'hAAAA, 16'hFFFF, 10'd392, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
